// File: rtl/rv_muldiv_iter.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Holds the pipeline via x_stall_req_o until the result is ready.
module rv_muldiv_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1,
    parameter int DIV_BITS = 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            x_stall_i,
    input  logic            x_kill_i,
    input  logic            d_valid_i,
    input  logic            d_is_muldiv_i,
    input  logic [2:0]      d_fun_i,
    input  logic [XLEN-1:0] d_rs1_i,
    input  logic [XLEN-1:0] d_rs2_i,
    output logic            x_stall_req_o,
    output logic [XLEN-1:0] x_rd_o,
    output logic            x_busy_o
);

    localparam int N_MUL = XLEN / MUL_BITS;
    localparam int N_DIV = XLEN / DIV_BITS;
    localparam int CW    = $clog2(XLEN);
    localparam int W2    = 2 * XLEN;

    localparam logic [CW-1:0] CNT_MUL = CW'(N_MUL - 1);
    localparam logic [CW-1:0] CNT_DIV = CW'(N_DIV - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]   cnt_q;
    logic [2:0]      fun_q;
    logic            neg_q;
    logic [W2-1:0]   opa_q;
    logic [XLEN-1:0] opb_q;
    logic [W2-1:0]   acc_q;
    logic [XLEN-1:0] res_q;

    logic            start;
    logic            is_div;
    logic            sgn1;
    logic            sgn2;
    logic            s1;
    logic            s2;
    logic            neg;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] spec_res;

    logic [W2-1:0]   partial;
    logic [W2-1:0]   acc_mul;
    logic [XLEN-1:0] rem_t;
    logic [XLEN-1:0] quo_t;
    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;
    logic [W2-1:0]   acc_step;
    logic [W2-1:0]   prod;
    logic [XLEN-1:0] dval;
    logic [XLEN-1:0] final_res;

    assign start  = d_valid_i & d_is_muldiv_i & ~x_kill_i & (state_q == IDLE);
    assign is_div = d_fun_i[2];

    // Operand signedness per funct3 (MUL low half is sign-agnostic).
    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        unique case (d_fun_i)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            3'd2:    sgn1 = 1'b1;
            default: ;
        endcase
    end

    // Magnitudes, result sign and the immediate divide corner cases.
    always_comb begin
        s1       = sgn1 & d_rs1_i[XLEN-1];
        s2       = sgn2 & d_rs2_i[XLEN-1];
        abs1     = s1 ? -d_rs1_i : d_rs1_i;
        abs2     = s2 ? -d_rs2_i : d_rs2_i;
        neg      = (is_div & d_fun_i[1]) ? s1 : (s1 ^ s2);
        div_zero = is_div & (d_rs2_i == '0);
        div_ovf  = is_div & ~d_fun_i[0] & (d_rs1_i == MIN_NEG)
                 & (d_rs2_i == '1);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            spec_res = d_fun_i[1] ? d_rs1_i : '1;
        end else begin
            spec_res = d_fun_i[1] ? '0 : d_rs1_i;
        end
    end

    // One iteration: shift-add for multiply, restoring steps for divide.
    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (opb_q[j]) begin
                partial = partial + (opa_q << j);
            end
        end
        acc_mul = acc_q + partial;

        rem_t = acc_q[W2-1:XLEN];
        quo_t = acc_q[XLEN-1:0];
        trial = '0;
        diff  = '0;
        for (int j = 0; j < DIV_BITS; j++) begin
            trial = {rem_t, quo_t[XLEN-1]};
            diff  = trial - {1'b0, opb_q};
            if (trial >= {1'b0, opb_q}) begin
                rem_t = diff[XLEN-1:0];
                quo_t = {quo_t[XLEN-2:0], 1'b1};
            end else begin
                rem_t = trial[XLEN-1:0];
                quo_t = {quo_t[XLEN-2:0], 1'b0};
            end
        end

        acc_step = fun_q[2] ? {rem_t, quo_t} : acc_mul;
    end

    // Sign fix and half/quotient/remainder selection on the last step.
    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        dval = fun_q[1] ? acc_step[W2-1:XLEN] : acc_step[XLEN-1:0];
        if (fun_q[2]) begin
            final_res = neg_q ? -dval : dval;
        end else if (fun_q[1:0] == 2'd0) begin
            final_res = prod[XLEN-1:0];
        end else begin
            final_res = prod[W2-1:XLEN];
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = special ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (x_kill_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (x_kill_i || !x_stall_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch on start, iteration while busy, result capture.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            fun_q <= '0;
            neg_q <= 1'b0;
            opa_q <= '0;
            opb_q <= '0;
            acc_q <= '0;
            res_q <= '0;
        end else if (start) begin
            fun_q <= d_fun_i;
            neg_q <= neg;
            opb_q <= abs2;
            if (is_div) begin
                cnt_q <= CNT_DIV;
                opa_q <= '0;
                acc_q <= {{XLEN{1'b0}}, abs1};
            end else begin
                cnt_q <= CNT_MUL;
                opa_q <= {{XLEN{1'b0}}, abs1};
                acc_q <= '0;
            end
            if (special) begin
                res_q <= spec_res;
            end
        end else if (state_q == BUSY && !x_kill_i) begin
            acc_q <= acc_step;
            opa_q <= opa_q << MUL_BITS;
            if (!fun_q[2]) begin
                opb_q <= opb_q >> MUL_BITS;
            end
            if (cnt_q == '0) begin
                res_q <= final_res;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign x_stall_req_o = start | ((state_q == BUSY) & ~x_kill_i);
    assign x_busy_o      = (state_q != IDLE);
    assign x_rd_o        = res_q;

endmodule
